// File: rtl/vdp_mac_seq.sv
// vdp_mac_seq: sequencer and result-capture stage for the single-cycle signed MAC
// (mac_nnbit_1cc) in the vector-dot-product datapath.
//
// Element pairs (in_g, in_e) arrive over a valid/ready handshake. Each cycle this
// block presents one pair to the MAC, or zeros on a bubble, so the accumulator
// holds. It clears the MAC on the last element of every K-element vector. It also
// registers the finished dot product behind a valid/ready result port.
//
// Parameters:
//   N - signed element width (must match the MAC)
//   K - elements per dot product, K >= 1 (must match the MAC)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   element-pair handshake; in_g/in_e signed elements
//   mac_rst             MAC accumulator clear
//   mac_g/mac_e         operands to the MAC (zero when no pair is accepted)
//   mac_o               combinational MAC output (acc + mac_g*mac_e)
//   res_valid/res_ready result handshake; res_data signed dot product
//
// Build option:
//   VDP_RELU_EN - when defined, negative results are captured as zero (ReLU).
//                 The handshake and timing are the same in both builds.
module vdp_mac_seq #(
  parameter int N = 8,
  parameter int K = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [N-1:0]    in_g,
  input  logic signed [N-1:0]    in_e,
  output logic                   mac_rst,
  output logic signed [N-1:0]    mac_g,
  output logic signed [N-1:0]    mac_e,
  input  logic signed [2*N+K-2:0] mac_o,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic signed [2*N+K-2:0] res_data
);

  localparam int W  = 2 * N + K - 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                res_valid_q, res_valid_d;
  logic signed [W-1:0] res_data_q, res_data_d;
  logic signed [W-1:0] cap_val;
  logic                last_el;
  logic                acc_fire;
  logic                capture;

  always_comb begin
    last_el = (cnt_q == LAST);
    // Only the last element of a vector can be blocked by an undrained result.
    in_ready = !rst && !(last_el && res_valid_q && !res_ready);
    acc_fire = in_valid && in_ready;
    capture  = acc_fire && last_el;
    mac_g    = acc_fire ? in_g : '0;
    mac_e    = acc_fire ? in_e : '0;
    // The last element clears the accumulator, so the next vector starts from zero.
    mac_rst  = rst || capture;
  end

`ifdef VDP_RELU_EN
  assign cap_val = mac_o[W-1] ? '0 : mac_o;
`else
  assign cap_val = mac_o;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (acc_fire) begin
      cnt_d = last_el ? '0 : cnt_q + 1'b1;
    end
    // A capture takes priority over a drain. This keeps res_valid high
    // back-to-back and gives full throughput.
    if (capture) begin
      res_data_d  = cap_val;
      res_valid_d = 1'b1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_vdp_mac_seq.sv
// Testbench for vdp_mac_seq. It builds three instances (K=1, K=3, K=4, N=8).
// Each instance is paired with a behavioural model of the MAC. A reference model
// tracks partial sums and pending results per instance and checks the DUT every
// cycle. Directed tables and sequences cover the documented corner cases.
module tb_vdp_mac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a       [3];
  logic              in_valid_a  [3];
  logic              res_ready_a [3];
  logic signed [7:0] in_g_a      [3];
  logic signed [7:0] in_e_a      [3];
  logic              in_ready_a  [3];
  logic              mac_rst_a   [3];
  logic signed [7:0] mac_g_a     [3];
  logic signed [7:0] mac_e_a     [3];
  logic              res_valid_a [3];
  int                res_data_a  [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int KK = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
    localparam int W  = 2 * 8 + KK - 1;
    logic signed [W-1:0] acc, prod, mac_o, res_data;

    // MAC behaviour: combinational acc + g*e, accumulator cleared by mac_rst
    assign prod  = W'(mac_g_a[gi]) * W'(mac_e_a[gi]);
    assign mac_o = acc + prod;
    always @(posedge clk) acc <= mac_rst_a[gi] ? '0 : mac_o;

    vdp_mac_seq #(.N(8), .K(KK)) u_dut (
      .clk      (clk),
      .rst      (rst_a[gi]),
      .in_valid (in_valid_a[gi]),
      .in_ready (in_ready_a[gi]),
      .in_g     (in_g_a[gi]),
      .in_e     (in_e_a[gi]),
      .mac_rst  (mac_rst_a[gi]),
      .mac_g    (mac_g_a[gi]),
      .mac_e    (mac_e_a[gi]),
      .mac_o    (mac_o),
      .res_valid(res_valid_a[gi]),
      .res_ready(res_ready_a[gi]),
      .res_data (res_data)
    );
    assign res_data_a[gi] = int'(res_data);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int psum   [3];
  int pcnt   [3];
  int expq   [3][$];
  int held   [3];
  bit held_v [3];

  function automatic int kval(int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction

  function automatic int rexp(int x);
`ifdef VDP_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called mid-cycle: inputs are stable for the coming posedge
  task automatic scoreboard();
    for (int i = 0; i < 3; i++) begin
      int  kk;
      bit  exp_valid, exp_ready, fire;
      kk        = kval(i);
      exp_valid = (expq[i].size() > 0);
      exp_ready = !rst_a[i] && !(pcnt[i] == kk - 1 && exp_valid && !res_ready_a[i]);
      fire      = in_valid_a[i] && exp_ready;
      chk($sformatf("K%0d res_valid", kk), int'(res_valid_a[i]), int'(exp_valid));
      chk($sformatf("K%0d in_ready", kk), int'(in_ready_a[i]), int'(exp_ready));
      chk($sformatf("K%0d mac_rst", kk), int'(mac_rst_a[i]),
          int'(rst_a[i] || (fire && pcnt[i] == kk - 1)));
      chk($sformatf("K%0d mac_g", kk), int'(mac_g_a[i]), fire ? int'(in_g_a[i]) : 0);
      chk($sformatf("K%0d mac_e", kk), int'(mac_e_a[i]), fire ? int'(in_e_a[i]) : 0);
      if (held_v[i] && res_valid_a[i])
        chk($sformatf("K%0d res_data stable", kk), res_data_a[i], held[i]);
      if (rst_a[i]) begin
        expq[i].delete();
        psum[i] = 0;
        pcnt[i] = 0;
        held_v[i] = 0;
        continue;
      end
      if (res_valid_a[i] && res_ready_a[i] && exp_valid) begin
        chk($sformatf("K%0d res_data", kk), res_data_a[i], expq[i][0]);
        void'(expq[i].pop_front());
      end
      held_v[i] = res_valid_a[i] && !res_ready_a[i];
      held[i]   = res_data_a[i];
      if (fire) begin
        psum[i] += int'(in_g_a[i]) * int'(in_e_a[i]);
        pcnt[i]++;
        if (pcnt[i] == kk) begin
          expq[i].push_back(rexp(psum[i]));
          psum[i] = 0;
          pcnt[i] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    scoreboard();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until it is accepted (bounded wait)
  task automatic send(int i, int g, int e);
    bit ok;
    ok = 0;
    in_valid_a[i] = 1'b1;
    in_g_a[i] = 8'(g);
    in_e_a[i] = 8'(e);
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready_a[i];
      scoreboard();
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept timeout", 0, 1);
    in_valid_a[i] = 1'b0;
  endtask

  typedef struct {
    int g;
    int e;
    int exp;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{g: 23,  e: 99,  exp: 2277};
    tbl[1] = '{g: 23,  e: -99, exp: -2277};
    tbl[2] = '{g: -23, e: 99,  exp: -2277};
    tbl[3] = '{g: -23, e: -99, exp: 2277};

    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1; in_valid_a[i] = 1'b0; res_ready_a[i] = 1'b1;
      in_g_a[i] = '0; in_e_a[i] = '0;
      psum[i] = 0; pcnt[i] = 0; held_v[i] = 0; held[i] = 0;
    end
    repeat (2) cycle();
    for (int i = 0; i < 3; i++) begin
      chk("reset res_valid", int'(res_valid_a[i]), 0);
      chk("reset res_data", res_data_a[i], 0);
      chk("reset in_ready", int'(in_ready_a[i]), 0);
      chk("reset mac_rst", int'(mac_rst_a[i]), 1);
      chk("reset mac_g", int'(mac_g_a[i]), 0);
    end
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
    cycle();

    // K=1: back-to-back pairs, one result per cycle
    for (int j = 0; j < 4; j++) begin
      send(0, tbl[j].g, tbl[j].e);
      chk("K1 tbl res_valid", int'(res_valid_a[0]), 1);
      chk("K1 tbl res_data", res_data_a[0], rexp(tbl[j].exp));
    end
    cycle();
    chk("K1 drained", int'(res_valid_a[0]), 0);

    // K=3: bubbles between elements
    send(1, 23, 99); repeat (2) cycle();
    send(1, -23, 99); repeat (2) cycle();
    chk("K3 no early result", int'(res_valid_a[1]), 0);
    send(1, 5, -4);
    chk("K3 bubble res_valid", int'(res_valid_a[1]), 1);
    chk("K3 bubble res_data", res_data_a[1], rexp(-20));
    cycle();
    chk("K3 bubble drained", int'(res_valid_a[1]), 0);

    // K=3: positive vector survives ReLU unchanged
    send(1, 23, 99); send(1, 0, 0); send(1, 0, 0);
    chk("K3 positive res_data", res_data_a[1], 2277);
    cycle();

    // K=3: output stall blocks only the last element; drain and accept together
    res_ready_a[1] = 1'b0;
    send(1, 23, 99); send(1, -23, 99); send(1, 5, -4);
    send(1, 1, 1); send(1, 2, 2);
    in_valid_a[1] = 1'b1; in_g_a[1] = 8'sd3; in_e_a[1] = 8'sd3;
    cycle();
    chk("K3 stall in_ready", int'(in_ready_a[1]), 0);
    chk("K3 stall held data", res_data_a[1], rexp(-20));
    res_ready_a[1] = 1'b1;
    #1;
    chk("K3 release in_ready", int'(in_ready_a[1]), 1);
    cycle();
    in_valid_a[1] = 1'b0;
    chk("K3 second res_valid", int'(res_valid_a[1]), 1);
    chk("K3 second res_data", res_data_a[1], 14);
    cycle();

    // K=4: extreme operands, no wrap in 19 bits
    for (int j = 0; j < 4; j++) send(2, -128, -128);
    chk("K4 max res_data", res_data_a[2], 65536);
    for (int j = 0; j < 4; j++) send(2, -128, 127);
    chk("K4 min res_data", res_data_a[2], rexp(-65024));
    cycle();

    // K=3: reset mid-vector with a pending result
    res_ready_a[1] = 1'b0;
    send(1, 23, 99); send(1, -23, 99); send(1, 5, -4);
    send(1, 7, 7); send(1, 9, 9);
    rst_a[1] = 1'b1;
    cycle();
    rst_a[1] = 1'b0;
    res_ready_a[1] = 1'b1;
    chk("K3 rst drops result", int'(res_valid_a[1]), 0);
    chk("K3 rst clears data", res_data_a[1], 0);
    send(1, 1, 1); send(1, 2, 2); send(1, 3, 3);
    chk("K3 after rst res_valid", int'(res_valid_a[1]), 1);
    chk("K3 after rst res_data", res_data_a[1], 14);
    cycle();

    // Randomized traffic, checked by the reference model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        rst_a[i]       = ($urandom_range(0, 63) == 0);
        in_valid_a[i]  = ($urandom_range(0, 3) != 0);
        in_g_a[i]      = 8'($urandom);
        in_e_a[i]      = 8'($urandom);
        res_ready_a[i] = ($urandom_range(0, 2) != 0);
      end
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b0; in_valid_a[i] = 1'b0; res_ready_a[i] = 1'b1;
    end
    repeat (3) cycle();
    for (int i = 0; i < 3; i++)
      chk("final drain", int'(res_valid_a[i]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
